// File: rtl/mcdf_ctrl_regs_if.sv
// mcdf_ctrl_regs_if: register command bus between the register initiator and the MCDF
// control/status register file.
//
// Signals:
//   cmd        2 bits     command: 00 idle, 01 write, 10 read, 11 illegal
//   cmd_addr   ADDR_WIDTH byte address
//   cmd_data_w DATA_WIDTH write data
//   cmd_data_r DATA_WIDTH registered read data (valid the cycle after a read)
//
// Modports:
//   master - register initiator (drives command, address, write data)
//   slave  - register file (drives read data)
interface mcdf_ctrl_regs_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [1:0]            cmd;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data_w;
    logic [DATA_WIDTH-1:0] cmd_data_r;

    modport master (
        output cmd,
        output cmd_addr,
        output cmd_data_w,
        input  cmd_data_r
    );

    modport slave (
        input  cmd,
        input  cmd_addr,
        input  cmd_data_w,
        output cmd_data_r
    );
endinterface

// File: rtl/mcdf_ctrl_regs.sv
// mcdf_ctrl_regs: MCDF control/status register file.
//
// Decodes the register command bus, holds per-slave configuration (enable, priority,
// packet length), exposes slave FIFO free space as read-only status and keeps a sticky
// illegal-access flag with a saturating count.
//
// Register map (byte addresses):
//   0x00/0x04/0x08  SLVn_RW  rw  [0] en, [2:1] prio, [5:3] len
//   0x10/0x14/0x18  SLVn_R   ro  [7:0] avail
//   0x20            ERR      rw  [0] sticky illegal flag (W1C), [15:8] count (cleared with flag)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus                 command bus (slave modport of mcdf_ctrl_regs_if)
//   slvN_avail_i        FIFO free entries of slave N
//   slv_pkt_boundary_i  per-slave packet-boundary pulse (shadow build only)
//   slvN_en_o           channel enable
//   slvN_prio_o         arbitration priority, 0 highest
//   slvN_len_o          packet length code
//
// Optional feature: define CTRL_REGS_SHADOW_EN to stage prio/len writes in a shadow copy
// that is transferred to the active outputs at a packet boundary or while the channel is
// disabled. DATA_WIDTH must be at least 16.
module mcdf_ctrl_regs #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mcdf_ctrl_regs_if.slave        bus,
    input  logic [7:0]             slv0_avail_i,
    input  logic [7:0]             slv1_avail_i,
    input  logic [7:0]             slv2_avail_i,
    input  logic [2:0]             slv_pkt_boundary_i,
    output logic                   slv0_en_o,
    output logic                   slv1_en_o,
    output logic                   slv2_en_o,
    output logic [1:0]             slv0_prio_o,
    output logic [1:0]             slv1_prio_o,
    output logic [1:0]             slv2_prio_o,
    output logic [2:0]             slv0_len_o,
    output logic [2:0]             slv1_len_o,
    output logic [2:0]             slv2_len_o
);

    typedef enum logic [1:0] {
        CmdIdle = 2'b00,
        CmdWr   = 2'b01,
        CmdRd   = 2'b10,
        CmdIll  = 2'b11
    } cmd_e;

    cmd_e                  cmd;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0][7:0]       avail;

    assign cmd   = cmd_e'(bus.cmd);
    assign wdata = bus.cmd_data_w;
    assign avail = {slv2_avail_i, slv1_avail_i, slv0_avail_i};

    // Reserved write-data bits have no storage.
    logic unused_wdata;
    assign unused_wdata = ^wdata[DATA_WIDTH-1:6];

    // ---------------------------------------------------------------- decode
    logic [2:0] rw_hit, ro_hit;
    logic       err_hit, mapped, is_wr, is_rd, illegal, err_clr;
    logic [2:0] wr_rw;

    always_comb begin
        rw_hit = '0;
        ro_hit = '0;
        for (int i = 0; i < 3; i++) begin
            rw_hit[i] = (bus.cmd_addr == ADDR_WIDTH'(4 * i));
            ro_hit[i] = (bus.cmd_addr == ADDR_WIDTH'(16 + 4 * i));
        end
        err_hit = (bus.cmd_addr == ADDR_WIDTH'(32));
        mapped  = (|rw_hit) | (|ro_hit) | err_hit;
        is_wr   = (cmd == CmdWr);
        is_rd   = (cmd == CmdRd);
        // Writes to read-only status are illegal as well as unmapped accesses.
        illegal = (cmd == CmdIll) | ((is_wr | is_rd) & ~mapped) | (is_wr & (|ro_hit));
        wr_rw   = {3{is_wr}} & rw_hit;
        err_clr = is_wr & err_hit & wdata[0];
    end

    // ---------------------------------------------------------------- config state
    logic [2:0]      en_q, en_d;
    logic [2:0][1:0] prio_q, prio_d;
    logic [2:0][2:0] len_q, len_d;
    logic [2:0][1:0] rd_prio;
    logic [2:0][2:0] rd_len;

    always_comb begin
        en_d = en_q;
        for (int i = 0; i < 3; i++) begin
            if (wr_rw[i]) begin
                en_d[i] = wdata[0];
            end
        end
    end

`ifdef CTRL_REGS_SHADOW_EN
    logic [2:0][1:0] sh_prio_q, sh_prio_d;
    logic [2:0][2:0] sh_len_q, sh_len_d;

    // Writes land in the shadow; the active copy only moves at a safe point so that a
    // packet in flight never sees its length or priority change underneath it.
    always_comb begin
        sh_prio_d = sh_prio_q;
        sh_len_d  = sh_len_q;
        prio_d    = prio_q;
        len_d     = len_q;
        for (int i = 0; i < 3; i++) begin
            if (wr_rw[i]) begin
                sh_prio_d[i] = wdata[2:1];
                sh_len_d[i]  = wdata[5:3];
            end
            if (slv_pkt_boundary_i[i] || !en_q[i]) begin
                prio_d[i] = sh_prio_q[i];
                len_d[i]  = sh_len_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_prio_q <= {3{2'd3}};
            sh_len_q  <= '0;
        end else begin
            sh_prio_q <= sh_prio_d;
            sh_len_q  <= sh_len_d;
        end
    end

    assign rd_prio = sh_prio_q;
    assign rd_len  = sh_len_q;
`else
    always_comb begin
        prio_d = prio_q;
        len_d  = len_q;
        for (int i = 0; i < 3; i++) begin
            if (wr_rw[i]) begin
                prio_d[i] = wdata[2:1];
                len_d[i]  = wdata[5:3];
            end
        end
    end

    assign rd_prio = prio_q;
    assign rd_len  = len_q;

    logic unused_boundary;
    assign unused_boundary = ^slv_pkt_boundary_i;
`endif

    // ---------------------------------------------------------------- error state
    logic       err_flag_q, err_flag_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (illegal) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (err_clr) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    // ---------------------------------------------------------------- read path
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = '0;
        if (is_rd && !illegal) begin
            for (int i = 0; i < 3; i++) begin
                if (rw_hit[i]) begin
                    rdata_d[5:0] = {rd_len[i], rd_prio[i], en_q[i]};
                end
                if (ro_hit[i]) begin
                    rdata_d[7:0] = avail[i];
                end
            end
            if (err_hit) begin
                rdata_d[15:8] = err_cnt_q;
                rdata_d[0]    = err_flag_q;
            end
        end
    end

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= '1;
            prio_q     <= {3{2'd3}};
            len_q      <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
            rdata_q    <= '0;
        end else begin
            en_q       <= en_d;
            prio_q     <= prio_d;
            len_q      <= len_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.cmd_data_r = rdata_q;

    assign slv0_en_o   = en_q[0];
    assign slv1_en_o   = en_q[1];
    assign slv2_en_o   = en_q[2];
    assign slv0_prio_o = prio_q[0];
    assign slv1_prio_o = prio_q[1];
    assign slv2_prio_o = prio_q[2];
    assign slv0_len_o  = len_q[0];
    assign slv1_len_o  = len_q[1];
    assign slv2_len_o  = len_q[2];

endmodule

// File: tb/tb_mcdf_ctrl_regs.sv
// tb_mcdf_ctrl_regs: self-checking bench for mcdf_ctrl_regs (default build).
// A register-map level model predicts every output; outputs are compared each cycle on
// the falling clock edge, plus literal checks from hand-worked scenarios.
module tb_mcdf_ctrl_regs;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] avail0, avail1, avail2;
    logic [2:0] boundary;
    logic       en0, en1, en2;
    logic [1:0] prio0, prio1, prio2;
    logic [2:0] len0, len1, len2;

    always #5 clk = ~clk;

    mcdf_ctrl_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mcdf_ctrl_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .slv0_avail_i       (avail0),
        .slv1_avail_i       (avail1),
        .slv2_avail_i       (avail2),
        .slv_pkt_boundary_i (boundary),
        .slv0_en_o          (en0),
        .slv1_en_o          (en1),
        .slv2_en_o          (en2),
        .slv0_prio_o        (prio0),
        .slv1_prio_o        (prio1),
        .slv2_prio_o        (prio2),
        .slv0_len_o         (len0),
        .slv1_len_o         (len1),
        .slv2_len_o         (len2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each SLVn_RW as its 6-bit value, ERR as flag + count, and the read data
    // expected on the bus after the most recent edge.
    int          m_rw [3];
    int          m_flag;
    int          m_cnt;
    logic [31:0] m_rd;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] c, input logic [7:0] a,
                              input logic [31:0] w);
        int  kind;   // 0 unmapped, 1 rw, 2 ro, 3 err
        int  idx;
        bit  bad;
        if (r) begin
            for (int i = 0; i < 3; i++) m_rw[i] = 7;
            m_flag = 0;
            m_cnt  = 0;
            m_rd   = 0;
            return;
        end
        kind = 0;
        idx  = 0;
        if (a == 8'h00 || a == 8'h04 || a == 8'h08) begin
            kind = 1;
            idx  = a / 4;
        end else if (a == 8'h10 || a == 8'h14 || a == 8'h18) begin
            kind = 2;
            idx  = (a - 16) / 4;
        end else if (a == 8'h20) begin
            kind = 3;
        end
        m_rd = 0;
        bad  = 0;
        case (c)
            2'b01: begin
                if (kind == 1) m_rw[idx] = int'(w[5:0]);
                else if (kind == 3) begin
                    if (w[0]) begin
                        m_flag = 0;
                        m_cnt  = 0;
                    end
                end else bad = 1;
            end
            2'b10: begin
                if (kind == 1) m_rd = 32'(m_rw[idx]);
                else if (kind == 2) m_rd = (idx == 0) ? 32'(avail0) :
                                           (idx == 1) ? 32'(avail1) : 32'(avail2);
                else if (kind == 3) m_rd = 32'(m_cnt * 256 + m_flag);
                else bad = 1;
            end
            2'b11: bad = 1;
            default: ;
        endcase
        if (bad) begin
            m_flag = 1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic check_all();
        logic [2:0] en_v;
        logic [1:0] pr_v [3];
        logic [2:0] ln_v [3];
        en_v  = {en2, en1, en0};
        pr_v[0] = prio0; pr_v[1] = prio1; pr_v[2] = prio2;
        ln_v[0] = len0;  ln_v[1] = len1;  ln_v[2] = len2;
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("en%0d", i),   32'(en_v[i]),  32'(m_rw[i] % 2));
            cmp($sformatf("prio%0d", i), 32'(pr_v[i]),  32'((m_rw[i] / 2) % 4));
            cmp($sformatf("len%0d", i),  32'(ln_v[i]),  32'((m_rw[i] / 8) % 8));
        end
        cmp("cmd_data_r", bus.cmd_data_r, m_rd);
    endtask

    // Drive one command at the falling edge, let the rising edge take it, compare after.
    task automatic cycle(input logic r, input logic [1:0] c, input logic [7:0] a,
                         input logic [31:0] w);
        rst            = r;
        bus.cmd        = c;
        bus.cmd_addr   = a;
        bus.cmd_data_w = w;
        boundary       = 3'($urandom);
        model_step(r, c, a, w);
        @(negedge clk);
        check_all();
    endtask

    logic [7:0] addr_pool [10];

    initial begin
        logic [1:0]  c;
        logic [7:0]  a;
        logic [31:0] w;
        addr_pool = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h0C, 8'h01, 8'h24};
        avail0 = 8'h11; avail1 = 8'h22; avail2 = 8'h33;
        rst = 1'b1;
        bus.cmd = 2'b00; bus.cmd_addr = '0; bus.cmd_data_w = '0;
        boundary = '0;

        // Reset and reset readback.
        cycle(1'b1, 2'b00, 8'h00, 32'h0);
        cycle(1'b1, 2'b00, 8'h00, 32'h0);
        cycle(1'b0, 2'b10, 8'h00, 32'h0); cmp("lit_rst_rd00", bus.cmd_data_r, 32'h7);
        cycle(1'b0, 2'b10, 8'h04, 32'h0); cmp("lit_rst_rd04", bus.cmd_data_r, 32'h7);
        cycle(1'b0, 2'b10, 8'h08, 32'h0); cmp("lit_rst_rd08", bus.cmd_data_r, 32'h7);
        cycle(1'b0, 2'b10, 8'h20, 32'h0); cmp("lit_rst_err", bus.cmd_data_r, 32'h0);
        cycle(1'b0, 2'b00, 8'h00, 32'h0); cmp("lit_idle_rd0", bus.cmd_data_r, 32'h0);

        // Config write and readback, reserved bits dropped.
        cycle(1'b0, 2'b01, 8'h04, 32'h2D);
        cmp("lit_en1", 32'(en1), 32'h1);
        cmp("lit_prio1", 32'(prio1), 32'h2);
        cmp("lit_len1", 32'(len1), 32'h5);
        cycle(1'b0, 2'b10, 8'h04, 32'h0); cmp("lit_rd04_2d", bus.cmd_data_r, 32'h2D);
        cycle(1'b0, 2'b01, 8'h04, 32'hFFFF_FFFF);
        cycle(1'b0, 2'b10, 8'h04, 32'h0); cmp("lit_rd04_3f", bus.cmd_data_r, 32'h3F);

        // Read-only status and an illegal write to it.
        avail2 = 8'h5A;
        cycle(1'b0, 2'b10, 8'h18, 32'h0); cmp("lit_rd18", bus.cmd_data_r, 32'h5A);
        cycle(1'b0, 2'b01, 8'h18, 32'hFF);
        cycle(1'b0, 2'b10, 8'h18, 32'h0); cmp("lit_rd18_keep", bus.cmd_data_r, 32'h5A);
        cycle(1'b0, 2'b10, 8'h20, 32'h0); cmp("lit_err_1", bus.cmd_data_r, 32'h101);

        // Count saturation and W1C clear.
        for (int i = 0; i < 300; i++) cycle(1'b0, 2'b11, 8'h00, 32'h0);
        cycle(1'b0, 2'b10, 8'h20, 32'h0); cmp("lit_err_sat", bus.cmd_data_r, 32'hFF01);
        cycle(1'b0, 2'b01, 8'h20, 32'h1);
        cycle(1'b0, 2'b10, 8'h20, 32'h0); cmp("lit_err_clr", bus.cmd_data_r, 32'h0);

        // Back-to-back write then read; enable drops right after the write.
        cycle(1'b0, 2'b01, 8'h00, 32'h0); cmp("lit_en0_off", 32'(en0), 32'h0);
        cycle(1'b0, 2'b10, 8'h00, 32'h0); cmp("lit_rd00_0", bus.cmd_data_r, 32'h0);

        // Reset while read data is in flight.
        cycle(1'b0, 2'b10, 8'h04, 32'h0);
        cycle(1'b1, 2'b10, 8'h04, 32'h0); cmp("lit_rst_discard", bus.cmd_data_r, 32'h0);
        cmp("lit_rst_en0", 32'(en0), 32'h1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            avail0 = 8'($urandom); avail1 = 8'($urandom); avail2 = 8'($urandom);
            c = 2'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            else a = addr_pool[$urandom_range(0, 9)];
            w = $urandom;
            if ($urandom_range(0, 31) == 0) w[0] = 1'b1;
            cycle(($urandom_range(0, 99) == 0), c, a, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mcdf_ctrl_regs.md
Name: mcdf_ctrl_regs

Overview:
- Control/status register file for the MCDF; directly consumes the register command bus (cmd, cmd_addr, cmd_data_w) driven by the register initiator and returns cmd_data_r.
- Drives per-slave configuration (enable, priority, packet length) to the slave channels and arbiter.
- Exposes slave FIFO free-space (avail) as read-only status.
- Adds a sticky error/statistics register for illegal accesses.

Parameters:
- ADDR_WIDTH, 8, width of cmd_addr.
- DATA_WIDTH, 32, width of cmd_data_w/cmd_data_r; must be >= 16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd  in  2  2'b00 IDLE, 2'b01 WR, 2'b10 RD, 2'b11 illegal
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_data_w  in  DATA_WIDTH  write data
- cmd_data_r  out  DATA_WIDTH  read data, registered
- slv0_avail / slv1_avail / slv2_avail  in  8 each  FIFO free entries
- slv_pkt_boundary  in  3  per-slave packet-boundary pulse; used only with the optional feature
- slv0_en / slv1_en / slv2_en  out  1 each  channel enable
- slv0_prio / slv1_prio / slv2_prio  out  2 each  arbitration priority, 0 highest
- slv0_len / slv1_len / slv2_len  out  3 each  packet length code

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state updates on rising clk.
- Register map (address / access / fields):
  - 0x00, 0x04, 0x08: SLVn_RW, read/write. bit0 en, bits2:1 prio, bits5:3 len, bits DATA_WIDTH-1:6 reserved.
  - 0x10, 0x14, 0x18: SLVn_R, read-only. bits7:0 avail, rest 0.
  - 0x20: ERR. bit0 sticky illegal flag, bits15:8 illegal-access count (saturates at 255), rest 0. Write-1-to-clear on bit0; any write to 0x20 with bit0=1 also clears the count.
- Reset values: SLVn_RW = 0x7 (en=1, prio=3, len=0); ERR = 0; cmd_data_r = 0; all config outputs reflect reset register values in the cycle after rst sampled high.
- WR: register updates at the clock edge sampling cmd=WR; config outputs change on that same edge (0-cycle visible next cycle). Reserved bits ignored.
- RD: cmd_data_r valid the cycle after cmd=RD, holds for exactly one cycle. Returns reserved bits as 0. SLVn_R returns avail sampled on the RD cycle.
- Non-RD cycles: cmd_data_r = 0 the following cycle.
- Illegal access = any of: cmd=2'b11; WR/RD to an unmapped address; WR to a read-only address (0x10–0x18). On an illegal access:
  - ERR bit0 is set.
  - Count increments, saturating at 255.
  - No register changes.
  - An illegal RD returns 0.
- Simultaneous W1C write to ERR in the same cycle as an illegal event cannot occur, because a single command per cycle is allowed. The clear wins; the write itself is legal.
- Back-to-back commands are accepted every cycle, with no stall and no ready signal.
- RD of a register in the cycle after WR to it returns the new value.
- rst mid-operation: any in-flight read data is discarded (cmd_data_r = 0 next cycle); all registers return to reset values.

Optional Feature:
- Macro CTRL_REGS_SHADOW_EN.
- With the macro defined:
  - WR updates a shadow copy of prio/len only.
  - Active slvN_prio/slvN_len load from the shadow on a cycle where slv_pkt_boundary[N]=1 or active slvN_en=0.
  - en always takes effect immediately.
  - RD of SLVn_RW returns shadow values.
- Without the macro: no shadow; slv_pkt_boundary is ignored; outputs follow registers as described above.

Test Plan:
- Reset: assert rst 2 cycles, then RD 0x00, 0x04, 0x08 -> cmd_data_r = 0x7 each, one cycle after each RD; ERR reads 0.
- Write 0x2D to 0x04 -> next cycle slv1_en=1, slv1_prio=2, slv1_len=5; RD 0x04 -> 0x2D. Write 0xFFFFFFFF -> reads 0x3F.
- slv2_avail=0x5A, RD 0x18 -> 0x0000005A; simultaneous WR 0x18 -> register unchanged, ERR bit0=1, count=1.
- 300 consecutive cmd=2'b11 cycles -> ERR reads 0x0000FF01; WR 0x20 data 0x1 -> ERR reads 0.
- Back-to-back WR 0x00=0x0, RD 0x00 -> read returns 0x0; slv0_en=0 the cycle after the WR.
- With CTRL_REGS_SHADOW_EN: en=1, WR 0x00=0x19 -> slv0_len/prio unchanged until slv_pkt_boundary[0] pulse, then len=3, prio=0 on the following cycle.
